reg_pipe: RTL and testbench
===========================

Name: reg_pipe

Overview:
- Parametrised, elastic successor to the single enabled flip-flop: a chain of DEPTH registers, each WIDTH bits wide, with a valid bit per stage.
- Uses a valid/ready handshake with backpressure and bubble collapsing, plus a global enable, a synchronous flush and an occupancy count.
- In the ReactionTimer datapath it sits between the stimulus/timestamp logic and the display/scoring logic, to delay and buffer timestamped events.

Parameters:
- WIDTH, 8, data bits per stage (>=1).
- DEPTH, 4, number of register stages (>=1); also the empty-pipe latency.
- CW, $clog2(DEPTH+1), width of the occupancy count (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  global advance enable; low freezes all state
- flush  input  1  synchronous clear of all valid bits
- in_valid  input  1  upstream data valid
- in_data  input  WIDTH  upstream data
- in_ready  output  1  pipe can accept in_data this cycle
- out_valid  output  1  stage DEPTH-1 holds valid data and enable=1
- out_data  output  WIDTH  data of stage DEPTH-1
- out_ready  input  1  downstream accepts this cycle
- count  output  CW  number of valid stages, 0..DEPTH

Behaviour:
- Reset: clk is the clock; reset is synchronous and active-high. While reset is high at a rising edge, every stage clears: all valid bits = 0, all data = 0. Hence count=0, out_valid=0, out_data=0. in_ready is combinationally 0 while reset is asserted. Reset has priority over flush and enable.
- Per-stage ready (combinational): rdy[i] = !v[i] | rdy[i+1], with rdy[DEPTH] = out_ready.
  - in_ready = enable & !flush & !reset & rdy[0].
  - out_valid = enable & v[DEPTH-1].
- Stage update at posedge, when enable=1, flush=0, reset=0:
  - If rdy[i]=1: v[i] <= v[i-1] and d[i] <= d[i-1]. For stage 0 the source is in_valid/in_data.
  - Else: hold.
  - Data registers load only when the source valid=1; stage data is otherwise held, so no toggling on bubbles.
- Bubbles: an empty stage always accepts, so gaps collapse under a downstream stall.
- Output transfer: completes when out_valid & out_ready. Input transfer: completes when in_valid & in_ready.
- Latency: an item accepted into an empty pipe at edge t is presented on out_valid/out_data after edge t+DEPTH-1, i.e. in the cycle following it. That is DEPTH cycles after the acceptance cycle.
- Throughput: 1 item/cycle with out_ready held at 1.
- enable=0: all valid and data registers hold; in_ready=0, out_valid=0; count still reports held occupancy. No transfer can complete in either direction.
- flush=1 (reset=0): all v[i] <= 0 regardless of enable; data registers hold. in_ready=0 that cycle, so no item is accepted. out_valid follows the pre-flush state that cycle; a downstream that handshakes in the flush cycle does consume that item. Next cycle count=0.
- count: registered. It is the sum of the next-state valid bits, updated every edge, and always equals popcount(v).
- Full: count=DEPTH and out_ready=0 give in_ready=0. Full with out_ready=1 gives in_ready=1: simultaneous push and pop, count unchanged.
- Empty: count=0, out_valid=0, in_ready=enable.
- Reset mid-operation: all in-flight items are dropped, with no partial output.
- DEPTH=1: degenerates to an enabled register with a valid bit and a pass-through ready.

Decomposition:
- Shared package reactiontimer_pkg holds a clog2-based helper constant function for count width, and default DATA_W=8 for timestamp events.
- One natural sub-module: reg_pipe_stage, holding WIDTH data, a valid bit, upstream/downstream ready, enable and flush. It is instantiated DEPTH times in a generate loop.
- The top level holds only the ready chain, the count adder and the output gating.

Test Plan:
- Reset then stream: enable=1, out_ready=1, DEPTH=4, WIDTH=8; push 0x11,0x22,0x33 on consecutive cycles -> out_valid first high 4 cycles after 0x11 is accepted; outputs 0x11,0x22,0x33 back-to-back; count peaks at 3 and returns to 0.
- Backpressure fill: out_ready=0; push 0xA0..0xA5 -> exactly 4 accepted (0xA0..0xA3); in_ready=0 once count=4; release out_ready -> 0xA0..0xA3 drain in order.
- Bubble collapse: push 0x01, idle 2 cycles, push 0x02, out_ready=0 throughout -> stages compact; count=2; on release, out_data=0x01 then 0x02 with no gap.
- Full with simultaneous push/pop: count=4, in_valid=1, out_ready=1 for 5 cycles -> count stays 4; output order preserved; no item lost.
- Enable freeze: count=2, then enable=0 for 3 cycles with in_valid=1, out_ready=1 -> in_ready=0, out_valid=0, count=2 and data unchanged; re-enable -> the same two items emerge.
- Flush and reset: count=3, assert flush one cycle with in_valid=1 -> next cycle count=0, out_valid=0, input not taken. Repeat with reset asserted mid-stream -> count=0, out_data=0.

Source files
------------

// File: rtl/reactiontimer_pkg.sv
// Shared constants and helpers for the ReactionTimer datapath.
// Timestamp event width and occupancy-counter sizing live here.
package reactiontimer_pkg;

    localparam int DATA_W = 8;

    // Bits needed to hold a count from 0 to depth inclusive.
    function automatic int count_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One elastic register stage: a data word plus a valid bit. It advances whenever
// it is empty or the stage downstream of it is advancing.
module reg_pipe_stage
    import reactiontimer_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             flush,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    input  logic             dn_ready,
    output logic             up_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             valid_next
);

    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;
    logic             advance;

    assign up_ready = !valid_reg || dn_ready;
    assign advance  = enable && !flush && up_ready;

    // The next valid bit is exported so the top can count occupancy one edge early.
    always_comb begin
        valid_next = valid_reg;
        if (reset || flush) begin
            valid_next = 1'b0;
        end else if (advance) begin
            valid_next = src_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else begin
            valid_reg <= valid_next;
            // Bubbles leave the data word untouched.
            if (advance && src_valid) begin
                data_reg <= src_data;
            end
        end
    end

    assign valid = valid_reg;
    assign data  = data_reg;

endmodule

// File: rtl/reg_pipe.sv
// Elastic delay line of DEPTH registered stages with valid/ready handshake,
// global enable, synchronous flush and a registered occupancy count.
module reg_pipe
    import reactiontimer_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = 4,
    parameter int CW    = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CW-1:0]    count
);

    // Index i is the input side of stage i; index DEPTH is the pipe output.
    logic [DEPTH:0]   rdy;
    logic [DEPTH:0]   link_valid;
    logic [WIDTH-1:0] link_data [DEPTH+1];
    logic [DEPTH-1:0] valid_next;

    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;

    assign rdy[DEPTH]   = out_ready;
    assign link_valid[0] = in_valid;
    assign link_data[0]  = in_data;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            reg_pipe_stage #(
                .WIDTH(WIDTH)
            ) u_stage (
                .clk       (clk),
                .reset     (reset),
                .enable    (enable),
                .flush     (flush),
                .src_valid (link_valid[gi]),
                .src_data  (link_data[gi]),
                .dn_ready  (rdy[gi+1]),
                .up_ready  (rdy[gi]),
                .valid     (link_valid[gi+1]),
                .data      (link_data[gi+1]),
                .valid_next(valid_next[gi])
            );
        end
    endgenerate

    always_comb begin
        count_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_next = count_next + CW'(valid_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign in_ready  = enable && !flush && !reset && rdy[0];
    assign out_valid = enable && link_valid[DEPTH];
    assign out_data  = link_data[DEPTH];
    assign count     = count_reg;

endmodule

// File: tb/tb_reg_pipe.sv
// Self-checking bench for reg_pipe (WIDTH=8, DEPTH=4): a negedge monitor keeps an
// in-order scoreboard of accepted items; scenario tasks check control behaviour.
module tb_reg_pipe;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb [$];

    reg_pipe #(
        .WIDTH(8),
        .DEPTH(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: push on input handshake, pop and compare on output handshake.
    always @(negedge clk) begin
        logic [7:0] exp_data;
        if (!reset && in_valid && in_ready) begin
            sb.push_back(in_data);
            $display("%0t push data=%02h", $time, in_data);
        end
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: out_data=%02h, expected no output", out_data);
            end else begin
                exp_data = sb.pop_front();
                if (out_data !== exp_data) begin
                    errors++;
                    $display("FAIL sb_data: out_data=%02h, expected %02h", out_data, exp_data);
                end else begin
                    $display("%0t pop  data=%02h", $time, out_data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (count == 0 && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; flush = 1'b0;
        in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b, expected 0", in_ready); end
        tick(); tick();
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d, expected 0", count); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
        checks++;
        if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %02h, expected 00", out_data); end
        reset = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL empty_in_ready: got %b, expected 1", in_ready); end
    endtask

    task automatic test_stream();
        int peak;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h11;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready: got %b, expected 1", in_ready); end
        tick();
        in_data = 8'h22; tick();
        in_data = 8'h33; tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (count !== 3'd3 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_pre_latency: count=%0d out_valid=%b, expected count=3 out_valid=0", count, out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h11) begin
            errors++;
            $display("FAIL stream_latency: out_valid=%b out_data=%02h, expected 1/11", out_valid, out_data);
        end
        peak = 3;
        for (int i = 0; i < 20; i++) begin
            if (count > peak) peak = count;
            if (count == 0) break;
            tick();
        end
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL stream_drain: count=%0d, expected 0", count); end
        checks++;
        if (peak != 3) begin errors++; $display("FAIL stream_peak: got %0d, expected 3", peak); end
    endtask

    task automatic test_backpressure();
        int acc;
        bit ok;
        out_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_data = 8'hA0 + 8'(k);
            #1;
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (acc != 4) begin errors++; $display("FAIL bp_accepted: got %0d, expected 4", acc); end
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: count=%0d in_ready=%b, expected 4/0", count, in_ready);
        end
        checks++;
        if (out_data !== 8'hA0) begin errors++; $display("FAIL bp_head: got %02h, expected A0", out_data); end
        out_ready = 1'b1;
        wait_empty(30, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_drain: count=%0d pending=%0d, expected 0/0", count, sb.size()); end
    endtask

    task automatic test_bubble();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h01; tick();
        in_valid = 1'b0; tick(); tick();
        in_valid = 1'b1; in_data = 8'h02; tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (count !== 3'd2 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bubble_compact: count=%0d in_ready=%b, expected 2/1", count, in_ready);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h01) begin
            errors++;
            $display("FAIL bubble_head: out_valid=%b out_data=%02h, expected 1/01", out_valid, out_data);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h02) begin
            errors++;
            $display("FAIL bubble_no_gap: out_valid=%b out_data=%02h, expected 1/02", out_valid, out_data);
        end
        tick();
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bubble_empty: count=%0d out_valid=%b, expected 0/0", count, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = 8'hB0 + 8'(k); tick();
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (count !== 3'd4) begin errors++; $display("FAIL b2b_fill: count=%0d, expected 4", count); end
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_data = 8'hC0 + 8'(k);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: cycle %0d got %b, expected 1", k, in_ready); end
            tick();
            checks++;
            if (count !== 3'd4) begin errors++; $display("FAIL b2b_count: cycle %0d got %0d, expected 4", k, count); end
        end
        in_valid = 1'b0;
        wait_empty(30, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_drain: count=%0d pending=%0d, expected 0/0", count, sb.size()); end
    endtask

    task automatic test_enable_freeze();
        bit ok;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hD0; tick();
        in_data = 8'hD1; tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        enable = 1'b0; in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL freeze_handshake: in_ready=%b out_valid=%b, expected 0/0", in_ready, out_valid);
            end
            checks++;
            if (count !== 3'd2 || out_data !== 8'hD0) begin
                errors++;
                $display("FAIL freeze_hold: count=%0d out_data=%02h, expected 2/D0", count, out_data);
            end
            tick();
        end
        enable = 1'b1; in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hD0) begin
            errors++;
            $display("FAIL freeze_resume: out_valid=%b out_data=%02h, expected 1/D0", out_valid, out_data);
        end
        wait_empty(30, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL freeze_drain: count=%0d pending=%0d, expected 0/0", count, sb.size()); end
    endtask

    task automatic test_flush();
        bit ok;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 8'hE0 + 8'(k); tick();
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d, expected 3", count); end
        flush = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b, expected 0", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: count=%0d out_valid=%b, expected 0/0", count, out_valid);
        end
        in_valid = 1'b1; in_data = 8'h5C; tick();
        in_valid = 1'b0; out_ready = 1'b1;
        wait_empty(30, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL flush_recover: count=%0d pending=%0d, expected 0/0", count, sb.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 8'h90 + 8'(k); tick();
        end
        out_ready = 1'b0; reset = 1'b1; in_valid = 1'b1; in_data = 8'h77;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready: got %b, expected 0", in_ready); end
        tick();
        reset = 1'b0; in_valid = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_clear: count=%0d out_valid=%b out_data=%02h, expected 0/0/00", count, out_valid, out_data);
        end
        in_valid = 1'b1; in_data = 8'h3C; tick();
        in_valid = 1'b0; out_ready = 1'b1;
        wait_empty(30, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rstmid_recover: count=%0d pending=%0d, expected 0/0", count, sb.size()); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble();
        test_back_to_back();
        test_enable_freeze();
        test_flush();
        test_reset_mid();
        tick();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d items, expected 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
